// File: rtl/dmem_ctrl_if.sv
// Bundles the hart-side dmem request port and the memory-side request/response channels of dmem_ctrl.
// The slave modport is the controller's view; the master modport is the hart/memory environment's view.
interface dmem_ctrl_if;
  logic [31:0] i_req_addr;
  logic        i_req_ren;
  logic        i_req_wen;
  logic [31:0] i_req_wdata;
  logic [3:0]  i_req_mask;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_err;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_req_addr, i_req_ren, i_req_wen, i_req_wdata, i_req_mask,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
    output o_busy, o_done, o_rdata, o_err,
    output o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask
  );

  modport master (
    output i_req_addr, i_req_ren, i_req_wen, i_req_wdata, i_req_mask,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata,
    input  o_busy, o_done, o_rdata, o_err,
    input  o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Bridges the hart's single-cycle dmem port to a variable-latency valid/ready memory, stalling the hart meanwhile.
// Optional build macro DMEM_CTRL_REQ_CHECK_EN rejects malformed requests without touching memory.
module dmem_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        i_clk,
  input  logic        i_rst,
  dmem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic              wen_q, wen_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic req_any;
  logic req_bad;
  logic timeout_hit;

  assign req_any = bus.i_req_ren | bus.i_req_wen;

`ifdef DMEM_CTRL_REQ_CHECK_EN
  assign req_bad = (bus.i_req_ren & bus.i_req_wen) | (bus.i_req_addr[1:0] != 2'b00) |
                   (bus.i_req_mask == 4'b0000);
`else
  assign req_bad = 1'b0;
`endif

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      wen_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      wen_q   <= wen_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_any) begin
          state_d = req_bad ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (bus.i_mem_ready) begin
          state_d = wen_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.i_mem_rvalid || timeout_hit) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields are captured once in IDLE; the completion status is only rewritten on the way into DONE.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    wen_d   = wen_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_any) begin
          addr_d  = bus.i_req_addr;
          wdata_d = bus.i_req_wdata;
          mask_d  = bus.i_req_mask;
          wen_d   = bus.i_req_wen;
          if (req_bad) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (bus.i_mem_ready) begin
          if (wen_q) begin
            err_d = 1'b0;
          end else begin
            cnt_d = '0;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response arriving on the timeout cycle still counts as a good read.
        if (bus.i_mem_rvalid) begin
          rdata_d = bus.i_mem_rdata;
          err_d   = 1'b0;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.o_busy      = 1'b0;
    bus.o_done      = 1'b0;
    bus.o_mem_valid = 1'b0;
    unique case (state_q)
      S_IDLE:  bus.o_busy = req_any;
      S_REQ: begin
        bus.o_busy      = 1'b1;
        bus.o_mem_valid = 1'b1;
      end
      S_WAIT:  bus.o_busy = 1'b1;
      S_DONE:  bus.o_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_rdata     = rdata_q;
  assign bus.o_err       = err_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wen   = wen_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_mem_mask  = mask_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: stimulus pushes expected completions, a negedge monitor pops and checks them.
module tb_dmem_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_ctrl_if bus();

  dmem_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(11)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   hs_cnt = 0;
  int   hs_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] rd, input logic err, input logic chk_rd);
    exp_t e;
    e.rd = rd;
    e.err = err;
    e.chk_rd = chk_rd;
    exp_q.push_back(e);
  endtask

  // Monitor: counts memory handshakes and scores every completion pulse.
  always @(negedge clk) begin
    #2;
    if (!rst && bus.o_mem_valid && bus.i_mem_ready) hs_cnt++;
    if (bus.o_done) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", {31'b0, bus.o_done}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_err", {31'b0, bus.o_err}, {31'b0, mon_e.err});
        if (mon_e.chk_rd) chk("done_rdata", bus.o_rdata, mon_e.rd);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.i_req_addr   = '0;
    bus.i_req_ren    = 1'b0;
    bus.i_req_wen    = 1'b0;
    bus.i_req_wdata  = '0;
    bus.i_req_mask   = 4'hF;
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h0BAD_0BAD;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", {31'b0, bus.o_busy}, 32'd0);
    chk("rst_done", {31'b0, bus.o_done}, 32'd0);
    chk("rst_mem_valid", {31'b0, bus.o_mem_valid}, 32'd0);
    chk("rst_rdata", bus.o_rdata, 32'd0);
    chk("rst_err", {31'b0, bus.o_err}, 32'd0);
    chk("rst_mem_addr", bus.o_mem_addr, 32'd0);

    // Stale response right after reset must be ignored.
    @(negedge clk); rst = 1'b0; #1;
    chk("stale_busy", {31'b0, bus.o_busy}, 32'd0);

    // Read, zero-wait memory.
    @(negedge clk);
    bus.i_mem_rvalid = 1'b0;
    bus.i_req_ren = 1'b1; bus.i_req_addr = 32'h100; bus.i_mem_ready = 1'b1;
    push_exp(32'hDEAD_BEEF, 1'b0, 1'b1);
    #1;
    chk("rd_idle_busy", {31'b0, bus.o_busy}, 32'd1);
    chk("rd_idle_mem_valid", {31'b0, bus.o_mem_valid}, 32'd0);
    @(negedge clk); #1;
    chk("rd_req_busy", {31'b0, bus.o_busy}, 32'd1);
    chk("rd_req_mem_valid", {31'b0, bus.o_mem_valid}, 32'd1);
    chk("rd_req_addr", bus.o_mem_addr, 32'h100);
    chk("rd_req_wen", {31'b0, bus.o_mem_wen}, 32'd0);
    @(negedge clk);
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'hDEAD_BEEF; #1;
    chk("rd_wait_busy", {31'b0, bus.o_busy}, 32'd1);
    chk("rd_wait_mem_valid", {31'b0, bus.o_mem_valid}, 32'd0);
    @(negedge clk);
    bus.i_mem_rvalid = 1'b0; bus.i_req_ren = 1'b0; #1;
    chk("rd_done_busy", {31'b0, bus.o_busy}, 32'd0);
    chk("rd_done_pulse", {31'b0, bus.o_done}, 32'd1);
    @(negedge clk); #1;
    chk("rd_after_done", {31'b0, bus.o_done}, 32'd0);
    chk("rd_rdata_hold", bus.o_rdata, 32'hDEAD_BEEF);

    // Write with four cycles of backpressure.
    @(negedge clk);
    bus.i_req_wen = 1'b1; bus.i_req_addr = 32'h200; bus.i_req_wdata = 32'h1234_5678;
    bus.i_req_mask = 4'b0011; bus.i_mem_ready = 1'b0;
    push_exp(32'h0, 1'b0, 1'b0);
    #1;
    chk("wr_idle_busy", {31'b0, bus.o_busy}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.i_mem_ready = (i == 4); #1;
      chk("wr_req_valid", {31'b0, bus.o_mem_valid}, 32'd1);
      chk("wr_req_addr", bus.o_mem_addr, 32'h200);
      chk("wr_req_wdata", bus.o_mem_wdata, 32'h1234_5678);
      chk("wr_req_mask", {28'b0, bus.o_mem_mask}, 32'h3);
      chk("wr_req_wen", {31'b0, bus.o_mem_wen}, 32'd1);
      chk("wr_req_busy", {31'b0, bus.o_busy}, 32'd1);
      chk("wr_req_done", {31'b0, bus.o_done}, 32'd0);
    end
    @(negedge clk);
    bus.i_req_wen = 1'b0; bus.i_mem_ready = 1'b0; bus.i_req_mask = 4'hF; #1;
    chk("wr_done_pulse", {31'b0, bus.o_done}, 32'd1);
    chk("wr_done_busy", {31'b0, bus.o_busy}, 32'd0);
    chk("wr_done_mem_valid", {31'b0, bus.o_mem_valid}, 32'd0);

    // Read timeout after eight WAIT cycles; a late response is dropped.
    @(negedge clk);
    bus.i_req_ren = 1'b1; bus.i_req_addr = 32'h300; bus.i_mem_ready = 1'b1;
    push_exp(32'h0, 1'b1, 1'b1);
    #1;
    @(negedge clk); #1;
    chk("to_req_valid", {31'b0, bus.o_mem_valid}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      chk("to_wait_busy", {31'b0, bus.o_busy}, 32'd1);
      chk("to_wait_done", {31'b0, bus.o_done}, 32'd0);
    end
    @(negedge clk);
    bus.i_req_ren = 1'b0; bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'h55AA_55AA; #1;
    chk("to_done_pulse", {31'b0, bus.o_done}, 32'd1);
    @(negedge clk); #1;
    chk("to_late_done", {31'b0, bus.o_done}, 32'd0);
    chk("to_late_busy", {31'b0, bus.o_busy}, 32'd0);
    chk("to_err_hold", {31'b0, bus.o_err}, 32'd1);
    @(negedge clk);
    bus.i_mem_rvalid = 1'b0; #1;
    chk("to_late_done2", {31'b0, bus.o_done}, 32'd0);
    chk("to_rdata_hold", bus.o_rdata, 32'd0);

    // Back-to-back read then write; the write presented in DONE is ignored until IDLE.
    @(negedge clk);
    bus.i_req_ren = 1'b1; bus.i_req_addr = 32'h400;
    push_exp(32'hCAFE_F00D, 1'b0, 1'b1);
    #1;
    @(negedge clk); #1;
    @(negedge clk);
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'hCAFE_F00D; #1;
    @(negedge clk);
    bus.i_mem_rvalid = 1'b0; bus.i_req_ren = 1'b0; bus.i_req_wen = 1'b1;
    bus.i_req_addr = 32'h404; bus.i_req_wdata = 32'hA5A5_A5A5; #1;
    chk("b2b_done1", {31'b0, bus.o_done}, 32'd1);
    chk("b2b_done1_busy", {31'b0, bus.o_busy}, 32'd0);
    chk("b2b_done1_mem_valid", {31'b0, bus.o_mem_valid}, 32'd0);
    @(negedge clk);
    push_exp(32'h0, 1'b0, 1'b0);
    #1;
    chk("b2b_idle_busy", {31'b0, bus.o_busy}, 32'd1);
    chk("b2b_idle_mem_valid", {31'b0, bus.o_mem_valid}, 32'd0);
    @(negedge clk); #1;
    chk("b2b_req_valid", {31'b0, bus.o_mem_valid}, 32'd1);
    chk("b2b_req_wen", {31'b0, bus.o_mem_wen}, 32'd1);
    chk("b2b_req_addr", bus.o_mem_addr, 32'h404);
    chk("b2b_req_wdata", bus.o_mem_wdata, 32'hA5A5_A5A5);
    @(negedge clk);
    bus.i_req_wen = 1'b0; #1;
    chk("b2b_done2", {31'b0, bus.o_done}, 32'd1);
    @(negedge clk); #1;
    chk("b2b_after", {31'b0, bus.o_busy}, 32'd0);

    // Reset during WAIT; the following response must not complete anything.
    @(negedge clk);
    bus.i_req_ren = 1'b1; bus.i_req_addr = 32'h500; #1;
    @(negedge clk); #1;
    chk("rst_mid_req_valid", {31'b0, bus.o_mem_valid}, 32'd1);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("rst_mid_wait_busy", {31'b0, bus.o_busy}, 32'd1);
    @(negedge clk);
    rst = 1'b0; bus.i_req_ren = 1'b0; bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'h1111_1111; #1;
    chk("rst_mid_mem_valid", {31'b0, bus.o_mem_valid}, 32'd0);
    chk("rst_mid_busy", {31'b0, bus.o_busy}, 32'd0);
    chk("rst_mid_done", {31'b0, bus.o_done}, 32'd0);
    chk("rst_mid_rdata", bus.o_rdata, 32'd0);
    @(negedge clk);
    bus.i_mem_rvalid = 1'b0; #1;
    chk("rst_mid_no_done", {31'b0, bus.o_done}, 32'd0);
    @(negedge clk); #1;
    chk("rst_mid_no_done2", {31'b0, bus.o_done}, 32'd0);

`ifdef DMEM_CTRL_REQ_CHECK_EN
    // Misaligned read and ren&wen are rejected without a memory request.
    @(negedge clk);
    bus.i_req_ren = 1'b1; bus.i_req_addr = 32'h102;
    push_exp(32'h0, 1'b1, 1'b1);
    #1;
    chk("chk_mis_busy", {31'b0, bus.o_busy}, 32'd1);
    @(negedge clk);
    bus.i_req_ren = 1'b0; #1;
    chk("chk_mis_done", {31'b0, bus.o_done}, 32'd1);
    chk("chk_mis_mem_valid", {31'b0, bus.o_mem_valid}, 32'd0);
    @(negedge clk);
    bus.i_req_ren = 1'b1; bus.i_req_wen = 1'b1; bus.i_req_addr = 32'h600;
    push_exp(32'h0, 1'b1, 1'b1);
    #1;
    chk("chk_rw_busy", {31'b0, bus.o_busy}, 32'd1);
    @(negedge clk);
    bus.i_req_ren = 1'b0; bus.i_req_wen = 1'b0; #1;
    chk("chk_rw_done", {31'b0, bus.o_done}, 32'd1);
    chk("chk_rw_mem_valid", {31'b0, bus.o_mem_valid}, 32'd0);
    hs_exp = 6;
`else
    // ren&wen together behaves as a write.
    @(negedge clk);
    bus.i_req_ren = 1'b1; bus.i_req_wen = 1'b1; bus.i_req_addr = 32'h600;
    bus.i_req_wdata = 32'h0F0F_0F0F;
    push_exp(32'h0, 1'b0, 1'b0);
    #1;
    chk("rw_idle_busy", {31'b0, bus.o_busy}, 32'd1);
    @(negedge clk); #1;
    chk("rw_req_valid", {31'b0, bus.o_mem_valid}, 32'd1);
    chk("rw_req_wen", {31'b0, bus.o_mem_wen}, 32'd1);
    @(negedge clk);
    bus.i_req_ren = 1'b0; bus.i_req_wen = 1'b0; #1;
    chk("rw_done", {31'b0, bus.o_done}, 32'd1);
    hs_exp = 7;
`endif

    @(negedge clk); #3;
    chk("exp_queue_empty", exp_q.size(), 32'd0);
    chk("handshake_count", hs_cnt, hs_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
